// File: rtl/blake2_msg_feeder.sv
// Byte-stream front end for the blake2 core: buffers one block plus a
// lookahead byte, feeds the block-load port, then collects the digest.
module blake2_msg_feeder #(
  parameter int BLK_BYTES = 64,
  parameter int LL_W      = 128,
  parameter int NN_MAX    = 64,
  parameter int F_GAP     = 105
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            nn_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [7:0]            s_data_i,
  input  logic                  s_last_i,
  input  logic                  s_empty_i,
  output logic                  block_first_o,
  output logic                  block_last_o,
  output logic                  data_v_o,
  output logic [5:0]            data_idx_o,
  output logic [7:0]            data_o,
  output logic [LL_W-1:0]       ll_o,
  input  logic                  finished_i,
  input  logic [7:0]            h_i,
  output logic [NN_MAX*8-1:0]   digest_o,
  output logic                  digest_valid_o
);

  typedef enum logic [2:0] {
    IDLE, FILL, PEEK, SEND, WAIT_F, RESULT, DONE
  } state_t;

  state_t     state;
  logic [7:0] buf_q [BLK_BYTES];
  logic [6:0] cnt;
  logic [5:0] idx;
  logic [6:0] gap;
  logic [7:0] la_byte;
  logic       la_last;
  logic [6:0] nn_q;
  logic       armed;
  logic [5:0] dig_k;
  logic       acc;
  logic       mark;

  assign acc  = s_valid_i & s_ready_o;
  // An empty beat only means "no byte" when it also ends the message.
  assign mark = s_last_i & s_empty_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      s_ready_o      <= 1'b0;
      block_first_o  <= 1'b0;
      block_last_o   <= 1'b0;
      data_v_o       <= 1'b0;
      data_idx_o     <= '0;
      data_o         <= '0;
      ll_o           <= '0;
      digest_o       <= '0;
      digest_valid_o <= 1'b0;
      cnt            <= '0;
      idx            <= '0;
      gap            <= '0;
      la_byte        <= '0;
      la_last        <= 1'b0;
      nn_q           <= '0;
      armed          <= 1'b0;
      dig_k          <= '0;
      for (int i = 0; i < BLK_BYTES; i++) buf_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          s_ready_o <= 1'b1;
          if (acc) begin
            nn_q           <= nn_i;
            block_first_o  <= 1'b1;
            digest_valid_o <= 1'b0;
            digest_o       <= '0;
            idx            <= '0;
            if (mark) begin
              cnt          <= '0;
              ll_o         <= '0;
              block_last_o <= 1'b1;
              s_ready_o    <= 1'b0;
              state        <= SEND;
            end else begin
              buf_q[0]     <= s_data_i;
              cnt          <= 7'd1;
              ll_o         <= LL_W'(1);
              block_last_o <= s_last_i;
              if (s_last_i) begin
                s_ready_o <= 1'b0;
                state     <= SEND;
              end else begin
                state <= FILL;
              end
            end
          end
        end
        FILL: begin
          if (acc) begin
            idx <= '0;
            if (mark) begin
              block_last_o <= 1'b1;
              s_ready_o    <= 1'b0;
              state        <= SEND;
            end else begin
              buf_q[cnt[5:0]] <= s_data_i;
              cnt             <= cnt + 7'd1;
              ll_o            <= ll_o + LL_W'(1);
              if (s_last_i) begin
                block_last_o <= 1'b1;
                s_ready_o    <= 1'b0;
                state        <= SEND;
              end else if (cnt == 7'd63) begin
                state <= PEEK;
              end
            end
          end
        end
        PEEK: begin
          // Hold the full block until we know whether it is the final one.
          if (acc) begin
            s_ready_o <= 1'b0;
            idx       <= '0;
            state     <= SEND;
            if (mark) begin
              block_last_o <= 1'b1;
            end else begin
              la_byte      <= s_data_i;
              la_last      <= s_last_i;
              ll_o         <= ll_o + LL_W'(1);
              block_last_o <= 1'b0;
            end
          end
        end
        SEND: begin
          data_v_o   <= 1'b1;
          data_idx_o <= idx;
          data_o     <= ({1'b0, idx} < cnt) ? buf_q[idx] : 8'h00;
          idx        <= idx + 6'd1;
          if (idx == 6'd63) begin
            gap   <= '0;
            state <= WAIT_F;
          end
        end
        WAIT_F: begin
          data_v_o   <= 1'b0;
          data_idx_o <= '0;
          data_o     <= '0;
          gap        <= gap + 7'd1;
          if (gap == 7'(F_GAP - 1)) begin
            if (block_last_o) begin
              armed <= 1'b0;
              state <= RESULT;
            end else begin
              block_first_o <= 1'b0;
              buf_q[0]      <= la_byte;
              cnt           <= 7'd1;
              idx           <= '0;
              if (la_last) begin
                block_last_o <= 1'b1;
                state        <= SEND;
              end else begin
                s_ready_o <= 1'b1;
                state     <= FILL;
              end
            end
          end
        end
        RESULT: begin
          // Core streams h one cycle after finished rises.
          if (!armed) begin
            if (finished_i) begin
              armed <= 1'b1;
              dig_k <= '0;
            end
          end else begin
            digest_o[{dig_k, 3'b000} +: 8] <= h_i;
            dig_k <= dig_k + 6'd1;
            if ({1'b0, dig_k} == nn_q - 7'd1) begin
              digest_valid_o <= 1'b1;
              s_ready_o      <= 1'b1;
              state          <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
